// File: rtl/control_pkg.sv
// Shared encodings for the integer ALU instruction decoder.
package control_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0000011;
    localparam logic [6:0] OP_I_ALT = 7'b0010011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        INST_R       = 3'b000,
        INST_I       = 3'b001,
        INST_INVALID = 3'b111
    } inst_type_e;

endpackage

// File: rtl/control_r_decode.sv
// Combinational opcode/funct decoder for R-type and I-type ALU instructions.
module control_r_decode
    import control_pkg::*;
(
    input  logic [31:0] instruction_word,
    output logic [3:0]  alu_ctrl,
    output logic        shamt_en,
    output logic        reg_write,
    output logic [2:0]  inst_type
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instruction_word[6:0];
    assign funct3 = instruction_word[14:12];
    assign funct7 = instruction_word[31:25];

    // Register specifiers never influence the decode.
    assign unused_fields = ^{instruction_word[24:15], instruction_word[11:7]};

    always_comb begin
        alu_ctrl  = ALU_ADD;
        shamt_en  = 1'b0;
        reg_write = 1'b0;
        inst_type = INST_INVALID;

        if (opcode == OP_R) begin
            if (funct7 == F7_BASE) begin
                alu_ctrl  = {1'b0, funct3};
                reg_write = 1'b1;
                inst_type = INST_R;
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                alu_ctrl  = ALU_SUB;
                reg_write = 1'b1;
                inst_type = INST_R;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                alu_ctrl  = ALU_SRA;
                reg_write = 1'b1;
                inst_type = INST_R;
            end
        end else if (opcode == OP_I_ALU || opcode == OP_I_ALT) begin
            reg_write = 1'b1;
            inst_type = INST_I;
            case (funct3)
                3'b001: begin
                    alu_ctrl = ALU_SLL;
                    shamt_en = 1'b1;
                end
                3'b101: begin
                    // Only imm bit 30 selects arithmetic vs logical shift.
                    alu_ctrl = instruction_word[30] ? ALU_SRA : ALU_SRL;
                    shamt_en = 1'b1;
                end
                default: alu_ctrl = {1'b0, funct3};
            endcase
        end
    end

endmodule

// File: rtl/control_r.sv
// Registered ALU-path instruction decoder with synchronous active-high reset.
module control_r
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_word,
    output logic [3:0]  alu_ctrl,
    output logic        shamt_en,
    output logic        reg_write,
    output logic [2:0]  inst_type
);

    logic [3:0] dec_alu_ctrl;
    logic       dec_shamt_en;
    logic       dec_reg_write;
    logic [2:0] dec_inst_type;

    control_r_decode u_decode (
        .instruction_word (instruction_word),
        .alu_ctrl         (dec_alu_ctrl),
        .shamt_en         (dec_shamt_en),
        .reg_write        (dec_reg_write),
        .inst_type        (dec_inst_type)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl  <= ALU_ADD;
            shamt_en  <= 1'b0;
            reg_write <= 1'b0;
            inst_type <= INST_INVALID;
        end else begin
            alu_ctrl  <= dec_alu_ctrl;
            shamt_en  <= dec_shamt_en;
            reg_write <= dec_reg_write;
            inst_type <= dec_inst_type;
        end
    end

endmodule

// File: tb/tb_control_r.sv
// Bench for control_r: directed cases plus randomized instructions against a rule-based model.
module tb_control_r;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction_word = 32'h0;
    logic [3:0]  alu_ctrl;
    logic        shamt_en;
    logic        reg_write;
    logic [2:0]  inst_type;

    int n_cmp = 0;
    int n_err = 0;

    control_r dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_word (instruction_word),
        .alu_ctrl         (alu_ctrl),
        .shamt_en         (shamt_en),
        .reg_write        (reg_write),
        .inst_type        (inst_type)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {alu_ctrl, shamt_en, reg_write, inst_type} from the instruction-set rules.
    function automatic logic [8:0] model(input logic r, input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int alu;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (r) return {4'd0, 1'b0, 1'b0, 3'b111};
        if (op == 7'h33) begin
            if (f7 == 7'h00) return {1'b0, f3, 1'b0, 1'b1, 3'b000};
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                alu = 8 + f3;
                return {alu[3:0], 1'b0, 1'b1, 3'b000};
            end
            return {4'd0, 1'b0, 1'b0, 3'b111};
        end
        if (op == 7'h03 || op == 7'h13) begin
            alu = f3;
            if (f3 == 3'd5 && w[30]) alu = alu + 8;
            return {alu[3:0], (f3 == 3'd1 || f3 == 3'd5), 1'b1, 3'b001};
        end
        return {4'd0, 1'b0, 1'b0, 3'b111};
    endfunction

    task automatic step(input logic r, input logic [31:0] w, input string tag);
        logic [8:0] e;
        @(negedge clk);
        rst = r;
        instruction_word = w;
        @(posedge clk);
        #1;
        e = model(r, w);
        check_eq({tag, ".alu_ctrl"},  {28'd0, alu_ctrl},  {28'd0, e[8:5]});
        check_eq({tag, ".shamt_en"},  {31'd0, shamt_en},  {31'd0, e[4]});
        check_eq({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, e[3]});
        check_eq({tag, ".inst_type"}, {29'd0, inst_type}, {29'd0, e[2:0]});
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'b10101, f3, 5'b00101, 7'b0000011};
    endfunction

    initial begin
        logic [31:0] w;
        logic [6:0]  op;
        int          sel;

        // Reset held for two edges; fixed expectations checked directly as well.
        step(1'b1, 32'hffff_ffff, "rst0");
        step(1'b1, mk_r(7'h00, 5'd4, 5'd21, 3'd0, 5'd5), "rst1");
        check_eq("rst_alu_const", {28'd0, alu_ctrl}, 32'h0);
        check_eq("rst_type_const", {29'd0, inst_type}, 32'h7);

        step(1'b0, mk_r(7'h00, 5'd4, 5'd21, 3'd0, 5'd5), "r_add");
        check_eq("r_add_alu_const", {28'd0, alu_ctrl}, 32'h0);
        check_eq("r_add_rw_const", {31'd0, reg_write}, 32'h1);
        step(1'b0, mk_r(7'h20, 5'd5, 5'd21, 3'd0, 5'd6), "r_sub");
        check_eq("r_sub_alu_const", {28'd0, alu_ctrl}, 32'h8);
        step(1'b0, mk_r(7'h00, 5'd4, 5'd21, 3'd1, 5'd5), "r_sll");
        step(1'b0, mk_r(7'h20, 5'd4, 5'd21, 3'd1, 5'd5), "r_alt_bad");
        check_eq("r_alt_bad_type_const", {29'd0, inst_type}, 32'h7);
        step(1'b0, mk_r(7'h20, 5'd4, 5'd21, 3'd5, 5'd0), "r_sra");
        check_eq("r_sra_alu_const", {28'd0, alu_ctrl}, 32'hd);

        step(1'b0, mk_i(12'b001000001001, 3'd0), "i_addi");
        step(1'b0, mk_i(12'b011101101101, 3'd7), "i_andi");
        check_eq("i_andi_alu_const", {28'd0, alu_ctrl}, 32'h7);
        step(1'b0, mk_i(12'b000011110101, 3'd3), "i_sltiu");
        step(1'b0, mk_i(12'b000011110101, 3'd5), "i_srli");
        check_eq("i_srli_alu_const", {28'd0, alu_ctrl}, 32'h5);
        check_eq("i_srli_sh_const", {31'd0, shamt_en}, 32'h1);
        step(1'b0, mk_i(12'b010011110101, 3'd5), "i_srai");
        check_eq("i_srai_alu_const", {28'd0, alu_ctrl}, 32'hd);
        step(1'b0, mk_i(12'b000011110101, 3'd1), "i_slli");
        step(1'b0, mk_i(12'b010011110101, 3'd6), "i_ori_b30");
        step(1'b0, {12'h7f0, 5'd3, 3'd4, 5'd0, 7'b0010011}, "i_alt_xori");

        step(1'b0, {25'h0abcdef, 7'b0110111}, "bad_op");
        check_eq("bad_op_rw_const", {31'd0, reg_write}, 32'h0);
        step(1'b0, mk_r(7'h00, 5'd4, 5'd21, 3'd6, 5'd5), "r_or");
        step(1'b1, mk_r(7'h00, 5'd4, 5'd21, 3'd6, 5'd5), "mid_rst");
        step(1'b0, mk_i(12'h123, 3'd2), "post_rst");

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = 7'b0110011;
                1: op = 7'b0000011;
                2: op = 7'b0010011;
                default: op = w[6:0];
            endcase
            w[6:0] = op;
            if (op == 7'b0110011) begin
                sel = $urandom_range(0, 2);
                if (sel == 0) w[31:25] = 7'h00;
                else if (sel == 1) w[31:25] = 7'h20;
            end
            step(($urandom_range(0, 19) == 0), w, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
